// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired microstep controller for the single-bus datapath.
//               Three-step fetch followed by an opcode-dependent execute.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_Data,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        r_enable,
    output logic        con_enable,
    output logic        outport_enable,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        BAout,
    output logic        PC_select,
    output logic        Z_LO_select,
    output logic        MDR_select,
    output logic        c_select,
    output logic        r_select,
    output logic        inport_select,
    output logic [4:0]  alu_instruction,
    output logic        run,
    output logic        instr_done
);

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_IN   = 5'b10110;
    localparam logic [4:0] c_OP_OUT  = 5'b10111;
    localparam logic [4:0] c_OP_HALT = 5'b11011;
    localparam logic [4:0] c_ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_opcode;
    logic       w_is_mem;
    logic       w_is_alu;
    logic       w_unused_ir;

    assign w_opcode    = IR_Data[31:27];
    assign w_unused_ir = &{1'b0, IR_Data[26:0]};
    assign w_is_mem    = (w_opcode == c_OP_LD) || (w_opcode == c_OP_LDI) || (w_opcode == c_OP_ST);
    assign w_is_alu    = (w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB) ||
                         (w_opcode == c_OP_AND) || (w_opcode == c_OP_OR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_RST;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next              = r_state;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        r_enable            = 1'b0;
        con_enable          = 1'b0;
        outport_enable      = 1'b0;
        read                = 1'b0;
        write               = 1'b0;
        Gra                 = 1'b0;
        Grb                 = 1'b0;
        Grc                 = 1'b0;
        BAout               = 1'b0;
        PC_select           = 1'b0;
        Z_LO_select         = 1'b0;
        MDR_select          = 1'b0;
        c_select            = 1'b0;
        r_select            = 1'b0;
        inport_select       = 1'b0;
        alu_instruction     = 5'b00000;
        run                 = (r_state != S_RST) && (r_state != S_HALT);
        instr_done          = 1'b0;

        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                PC_select  = 1'b1;
                MAR_enable = 1'b1;
                w_next     = S_T1;
            end
            S_T1: begin
                PC_increment_enable = 1'b1;
                read                = 1'b1;
                MDR_enable          = 1'b1;
                w_next              = S_T2;
            end
            S_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
                w_next     = S_T3;
            end
            S_T3: begin
                w_next = S_T0;
                if (w_is_mem) begin
                    // Effective address base: R[rb], or 0 when rb is r0
                    Grb      = 1'b1;
                    BAout    = 1'b1;
                    Y_enable = 1'b1;
                    w_next   = S_T4;
                end else if (w_is_alu) begin
                    Grb      = 1'b1;
                    r_select = 1'b1;
                    Y_enable = 1'b1;
                    w_next   = S_T4;
                end else if (w_opcode == c_OP_IN) begin
                    inport_select = 1'b1;
                    Gra           = 1'b1;
                    r_enable      = 1'b1;
                    instr_done    = 1'b1;
                end else if (w_opcode == c_OP_OUT) begin
                    Gra            = 1'b1;
                    r_select       = 1'b1;
                    outport_enable = 1'b1;
                    instr_done     = 1'b1;
                end else if (w_opcode == c_OP_HALT) begin
                    instr_done = 1'b1;
                    w_next     = S_HALT;
                end else begin
                    instr_done = 1'b1;
                end
            end
            S_T4: begin
                w_next = S_T0;
                if (w_is_mem) begin
                    c_select        = 1'b1;
                    alu_instruction = c_ALU_ADD;
                    Z_enable        = 1'b1;
                    w_next          = S_T5;
                end else if (w_is_alu) begin
                    Grc             = 1'b1;
                    r_select        = 1'b1;
                    alu_instruction = w_opcode;
                    Z_enable        = 1'b1;
                    w_next          = S_T5;
                end
            end
            S_T5: begin
                w_next = S_T0;
                if ((w_opcode == c_OP_LD) || (w_opcode == c_OP_ST)) begin
                    Z_LO_select = 1'b1;
                    MAR_enable  = 1'b1;
                    w_next      = S_T6;
                end else if ((w_opcode == c_OP_LDI) || w_is_alu) begin
                    Z_LO_select = 1'b1;
                    Gra         = 1'b1;
                    r_enable    = 1'b1;
                    instr_done  = 1'b1;
                end
            end
            S_T6: begin
                w_next = S_T0;
                if (w_opcode == c_OP_LD) begin
                    read       = 1'b1;
                    MDR_enable = 1'b1;
                    w_next     = S_T7;
                end else if (w_opcode == c_OP_ST) begin
                    Gra        = 1'b1;
                    r_select   = 1'b1;
                    MDR_enable = 1'b1;
                    w_next     = S_T7;
                end
            end
            S_T7: begin
                w_next = S_T0;
                if (w_opcode == c_OP_LD) begin
                    MDR_select = 1'b1;
                    Gra        = 1'b1;
                    r_enable   = 1'b1;
                    instr_done = 1'b1;
                end else if (w_opcode == c_OP_ST) begin
                    write      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    // Packed view of every DUT output, one bit per control line
    localparam logic [28:0] INSEL  = 29'd1 << 0;
    localparam logic [28:0] RSEL   = 29'd1 << 1;
    localparam logic [28:0] CSEL   = 29'd1 << 2;
    localparam logic [28:0] MDRSEL = 29'd1 << 3;
    localparam logic [28:0] ZLO    = 29'd1 << 4;
    localparam logic [28:0] PCSEL  = 29'd1 << 5;
    localparam logic [28:0] BAOUT  = 29'd1 << 6;
    localparam logic [28:0] GRC    = 29'd1 << 7;
    localparam logic [28:0] GRB    = 29'd1 << 8;
    localparam logic [28:0] GRA    = 29'd1 << 9;
    localparam logic [28:0] WRITE  = 29'd1 << 10;
    localparam logic [28:0] READ   = 29'd1 << 11;
    localparam logic [28:0] OUTEN  = 29'd1 << 12;
    localparam logic [28:0] REN    = 29'd1 << 14;
    localparam logic [28:0] MDREN  = 29'd1 << 15;
    localparam logic [28:0] MAREN  = 29'd1 << 16;
    localparam logic [28:0] ZEN    = 29'd1 << 17;
    localparam logic [28:0] YEN    = 29'd1 << 18;
    localparam logic [28:0] IREN   = 29'd1 << 19;
    localparam logic [28:0] PCINC  = 29'd1 << 20;
    localparam logic [28:0] ALU3   = 29'd3 << 22;
    localparam logic [28:0] ALU4   = 29'd4 << 22;
    localparam logic [28:0] ALU5   = 29'd5 << 22;
    localparam logic [28:0] DONE   = 29'd1 << 27;
    localparam logic [28:0] RUN    = 29'd1 << 28;
    localparam logic [28:0] NONE   = 29'd0;

    logic        clk;
    logic        r_reset;
    logic [31:0] r_ir;
    logic        w_pc_en, w_pc_inc, w_ir_en, w_y_en, w_z_en, w_mar_en, w_mdr_en;
    logic        w_r_en, w_con_en, w_out_en, w_read, w_write, w_gra, w_grb, w_grc;
    logic        w_baout, w_pc_sel, w_zlo_sel, w_mdr_sel, w_c_sel, w_r_sel, w_in_sel;
    logic [4:0]  w_alu;
    logic        w_run, w_done;
    logic [28:0] w_outs;
    int          checks;
    int          failures;

    control_sequencer dut (
        .clk                 (clk),
        .reset               (r_reset),
        .IR_Data             (r_ir),
        .PC_enable           (w_pc_en),
        .PC_increment_enable (w_pc_inc),
        .IR_enable           (w_ir_en),
        .Y_enable            (w_y_en),
        .Z_enable            (w_z_en),
        .MAR_enable          (w_mar_en),
        .MDR_enable          (w_mdr_en),
        .r_enable            (w_r_en),
        .con_enable          (w_con_en),
        .outport_enable      (w_out_en),
        .read                (w_read),
        .write               (w_write),
        .Gra                 (w_gra),
        .Grb                 (w_grb),
        .Grc                 (w_grc),
        .BAout               (w_baout),
        .PC_select           (w_pc_sel),
        .Z_LO_select         (w_zlo_sel),
        .MDR_select          (w_mdr_sel),
        .c_select            (w_c_sel),
        .r_select            (w_r_sel),
        .inport_select       (w_in_sel),
        .alu_instruction     (w_alu),
        .run                 (w_run),
        .instr_done          (w_done)
    );

    assign w_outs = {w_run, w_done, w_alu, w_pc_en, w_pc_inc, w_ir_en, w_y_en, w_z_en,
                     w_mar_en, w_mdr_en, w_r_en, w_con_en, w_out_en, w_read, w_write,
                     w_gra, w_grb, w_grc, w_baout, w_pc_sel, w_zlo_sel, w_mdr_sel,
                     w_c_sel, w_r_sel, w_in_sel};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [28:0] exp);
        checks++;
        assert (w_outs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, w_outs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [28:0] exp);
        @(negedge clk);
        chk(tag, exp);
    endtask

    // Opcode is scrambled during T0/T1 and the real one presented in T2
    task automatic fetch(input string tag, input logic [4:0] op);
        step({tag, "_T0"}, RUN | PCSEL | MAREN);
        r_ir = 32'hFFFF_FFFF;
        step({tag, "_T1"}, RUN | PCINC | READ | MDREN);
        r_ir = {op, 27'h0000005};
        step({tag, "_T2"}, RUN | MDRSEL | IREN);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        r_reset  = 1'b1;
        r_ir     = 32'h0;

        step("reset_c0", NONE);
        step("reset_c1", NONE);
        r_reset = 1'b0;

        // ldi: 0x08800005 -> opcode 00001
        fetch("ldi", 5'b00001);
        step("ldi_T3", RUN | GRB | BAOUT | YEN);
        step("ldi_T4", RUN | CSEL | ALU3 | ZEN);
        step("ldi_T5", RUN | ZLO | GRA | REN | DONE);

        fetch("ld", 5'b00000);
        step("ld_T3", RUN | GRB | BAOUT | YEN);
        step("ld_T4", RUN | CSEL | ALU3 | ZEN);
        step("ld_T5", RUN | ZLO | MAREN);
        step("ld_T6", RUN | READ | MDREN);
        step("ld_T7", RUN | MDRSEL | GRA | REN | DONE);

        fetch("st", 5'b00010);
        step("st_T3", RUN | GRB | BAOUT | YEN);
        step("st_T4", RUN | CSEL | ALU3 | ZEN);
        step("st_T5", RUN | ZLO | MAREN);
        step("st_T6", RUN | GRA | RSEL | MDREN);
        step("st_T7", RUN | WRITE | DONE);

        fetch("sub", 5'b00100);
        step("sub_T3", RUN | GRB | RSEL | YEN);
        step("sub_T4", RUN | GRC | RSEL | ALU4 | ZEN);
        step("sub_T5", RUN | ZLO | GRA | REN | DONE);

        fetch("and", 5'b00101);
        step("and_T3", RUN | GRB | RSEL | YEN);
        step("and_T4", RUN | GRC | RSEL | ALU5 | ZEN);
        step("and_T5", RUN | ZLO | GRA | REN | DONE);

        fetch("out", 5'b10111);
        step("out_T3", RUN | GRA | RSEL | OUTEN | DONE);

        fetch("in", 5'b10110);
        step("in_T3", RUN | INSEL | GRA | REN | DONE);

        fetch("unk", 5'b11111);
        step("unk_T3", RUN | DONE);

        fetch("nop", 5'b11010);
        step("nop_T3", RUN | DONE);

        fetch("halt", 5'b11011);
        step("halt_T3", RUN | DONE);
        for (int i = 0; i < 12; i++) step("halt_hold", NONE);

        r_reset = 1'b1;
        #1 chk("halt_reset", NONE);
        @(negedge clk);
        r_reset = 1'b0;
        r_ir    = 32'h0;

        // ld interrupted by an off-edge reset during T5
        fetch("ld2", 5'b00000);
        step("ld2_T3", RUN | GRB | BAOUT | YEN);
        step("ld2_T4", RUN | CSEL | ALU3 | ZEN);
        step("ld2_T5", RUN | ZLO | MAREN);
        #2 r_reset = 1'b1;
        #1 chk("midreset_async", NONE);
        step("midreset_hold", NONE);
        r_reset = 1'b0;

        fetch("post", 5'b00011);
        step("post_T3", RUN | GRB | RSEL | YEN);
        step("post_T4", RUN | GRC | RSEL | ALU3 | ZEN);
        step("post_T5", RUN | ZLO | GRA | REN | DONE);
        step("post_next_T0", RUN | PCSEL | MAREN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the single-bus datapath one microstep per clock. It runs a three-step fetch (T0–T2), then an opcode-dependent execute sequence (T3–T7), then returns to fetch. Every register-enable, bus-select, memory and ALU control line the datapath exposes comes from this block, which replaces the per-instruction state machines now hand-coded in each testbench. It sits beside the datapath, reads only the IR opcode field, and drives the datapath control ports by name.

## Interface
- Parameters: none. Opcode and state encodings are fixed below.
- `clk` — input, 1 — system clock; all state changes on the rising edge.
- `reset` — input, 1 — asynchronous, active-high; forces the `RST` state.
- `IR_Data` — input, 32 — datapath IR contents; only `IR_Data[31:27]` (opcode) is used.
- `PC_enable`, `PC_increment_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `r_enable`, `con_enable`, `outport_enable` — output, 1 each — datapath register loads.
- `read`, `write` — output, 1 each — memory read (MDR input mux) and memory write.
- `Gra`, `Grb`, `Grc`, `BAout` — output, 1 each — register select/encode controls.
- `PC_select`, `Z_LO_select`, `MDR_select`, `c_select`, `r_select`, `inport_select` — output, 1 each — bus source selects; at most one high per cycle.
- `alu_instruction` — output, 5 — ALU opcode.
- `run` — output, 1 — high while executing; low in `RST` and `HALT`.
- `instr_done` — output, 1 — one-cycle pulse in the final execute step of each instruction.

## Operation
- Opcodes (`IR_Data[31:27]`):
  - `00000` ld
  - `00001` ldi
  - `00010` st
  - `00011` add, `00100` sub, `00101` and, `00110` or
  - `10110` in, `10111` out
  - `11010` nop, `11011` halt
  - Any other opcode is treated as nop.
- States: `RST`, `T0`–`T7`, `HALT`. Outputs are a combinational decode of the registered state and the opcode; every signal not listed for a state is 0. `alu_instruction` is `00000` unless listed.
- `RST`: all outputs 0; next state `T0`.
- Fetch (all opcodes):
  - `T0`: `PC_select`, `MAR_enable`.
  - `T1`: `PC_increment_enable`, `read`, `MDR_enable`.
  - `T2`: `MDR_select`, `IR_enable`; next `T3`.
- ld:
  - `T3`: `Grb`, `BAout`, `Y_enable`.
  - `T4`: `c_select`, `alu_instruction=00011`, `Z_enable`.
  - `T5`: `Z_LO_select`, `MAR_enable`.
  - `T6`: `read`, `MDR_enable`.
  - `T7`: `MDR_select`, `Gra`, `r_enable`, `instr_done` → `T0`.
- ldi: `T3`/`T4` as ld; `T5`: `Z_LO_select`, `Gra`, `r_enable`, `instr_done` → `T0`.
- st:
  - `T3`–`T5` as ld.
  - `T6`: `Gra`, `r_select`, `MDR_enable` (`read`=0).
  - `T7`: `write`, `instr_done` → `T0`.
- ALU ops:
  - `T3`: `Grb`, `r_select`, `Y_enable`.
  - `T4`: `Grc`, `r_select`, `alu_instruction` = opcode, `Z_enable`.
  - `T5`: `Z_LO_select`, `Gra`, `r_enable`, `instr_done` → `T0`.
- in: `T3`: `inport_select`, `Gra`, `r_enable`, `instr_done` → `T0`.
- out: `T3`: `Gra`, `r_select`, `outport_enable`, `instr_done` → `T0`.
- nop/unknown: `T3`: `instr_done` → `T0`.
- halt: `T3`: `instr_done` → `HALT`. `HALT` holds with all outputs 0 and `run`=0; only `reset` leaves it.
- `run`=1 in `T0`–`T7`.
- `PC_enable` and `con_enable` are reserved for branch/jump support and are held at 0.

## Timing
- Reset asserted at any time, including mid-instruction: state becomes `RST` immediately and all outputs go 0 without waiting for a clock edge. After release, the first rising edge moves to `T0`.
- One microstep per clock. Instruction lengths including fetch:
  - ld, st: 8 cycles
  - ldi, ALU ops: 6 cycles
  - in, out, nop: 4 cycles
  - halt: 4 cycles, then stops in `HALT`
- The opcode is decoded from `IR_Data` only in `T3`–`T7`. IR loads at the edge ending `T2`, so its value is stable throughout execute. Opcode changes during `T0`–`T2` have no effect.
- Outputs change only after a state edge or reset; they are stable for the whole cycle, and the datapath samples them on the next rising edge.
- The datapath memory returns read data within one cycle (data valid for the `MDR` load at the end of `T1`/`T6`).

## Test plan
- Reset/fetch: hold `reset` high for 2 cycles, release → all outputs 0 during reset; then `T0`: `PC_select`=`MAR_enable`=1, `T1`: `read`=`MDR_enable`=`PC_increment_enable`=1, `T2`: `MDR_select`=`IR_enable`=1.
- ldi: `IR_Data`=`0x08800005` → `T5` asserts `Z_LO_select`+`Gra`+`r_enable`; `instr_done` pulses exactly once; next cycle is `T0`; total 6 cycles.
- ld/st: opcode `00000`, then `00010` → 8 cycles each; `T4` `alu_instruction`=`00011`; st `T7` has `write`=1 and `read`=0; ld `T6` has `read`=1.
- ALU + out: opcode `00100` → `T4` `alu_instruction`=`00100` with `Grc`=1; opcode `10111` → `T3` `outport_enable`=`Gra`=`r_select`=1, `r_enable`=0.
- halt and unknown: opcode `11111` → behaves as nop (4 cycles); opcode `11011` → `HALT`, `run`=0, outputs stay 0 for 10+ cycles; `reset` restarts at `T0`.
- Mid-instruction reset: assert `reset` asynchronously (off-edge) during ld `T5` → outputs 0 within the same cycle; after release, the sequence resumes from `T0`.
